// File: rtl/mem_stage_pkg.sv
// Shared definitions for the MEM stage: memory-operation encodings and memory sizing.
package mem_stage_pkg;

    typedef enum logic [3:0] {
        OP_NONE = 4'd0,
        OP_LW   = 4'd1,
        OP_LH   = 4'd2,
        OP_LHU  = 4'd3,
        OP_LB   = 4'd4,
        OP_LBU  = 4'd5,
        OP_SW   = 4'd6,
        OP_SH   = 4'd7,
        OP_SB   = 4'd8
    } mem_op_t;

    localparam int unsigned DM_WORDS_DEF = 1024;
    localparam int unsigned DM_BYTES     = 4 * DM_WORDS_DEF;

    function automatic logic op_is_load(input mem_op_t op);
        return (op == OP_LW) || (op == OP_LH) || (op == OP_LHU) ||
               (op == OP_LB) || (op == OP_LBU);
    endfunction

    function automatic logic op_is_store(input mem_op_t op);
        return (op == OP_SW) || (op == OP_SH) || (op == OP_SB);
    endfunction

endpackage

// File: rtl/mem_stage_load_ext.sv
// Load extender: picks the byte/halfword lane out of a memory word and sign/zero-extends it.
module load_ext
    import mem_stage_pkg::*;
(
    input  logic [31:0] word_i,
    input  logic [1:0]  lane_i,
    input  mem_op_t     op_i,
    output logic [31:0] data_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = word_i[8*lane_i +: 8];
        half_sel = lane_i[1] ? word_i[31:16] : word_i[15:0];
        data_o   = '0;
        case (op_i)
            OP_LW:   data_o = word_i;
            OP_LH:   data_o = {{16{half_sel[15]}}, half_sel};
            OP_LHU:  data_o = {16'h0, half_sel};
            OP_LB:   data_o = {{24{byte_sel[7]}}, byte_sel};
            OP_LBU:  data_o = {24'h0, byte_sel};
            default: data_o = '0;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// MIPS memory-access stage: private byte-enabled data memory, load extension,
// alignment/range checking and the MEM/WB pipeline register.
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int unsigned DM_WORDS = DM_WORDS_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall_in,
    input  logic [31:0] pc_in,
    input  logic [31:0] instructure_in,
    input  logic [5:0]  instr_code_in,
    input  logic [3:0]  mem_op_in,
    input  logic [31:0] alu_result_in,
    input  logic [31:0] store_data_in,
    output logic [31:0] pc_out,
    output logic [31:0] instructure_out,
    output logic [5:0]  instr_code_out,
    output logic [31:0] alu_result_out,
    output logic [31:0] mem_read_data_out,
    output logic        addr_err_out
);

    localparam int unsigned AW         = $clog2(DM_WORDS);
    localparam logic [32:0] ADDR_LIMIT = 33'(4 * DM_WORDS);

    logic [31:0] mem_q [DM_WORDS];

    mem_op_t     op;
    logic        is_load;
    logic        is_store;
    logic        misaligned;
    logic        out_of_range;
    logic        err;
    logic [AW-1:0] idx;
    logic [1:0]  lane;
    logic [31:0] rd_word;
    logic [31:0] ext_data;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        wr_en;

    logic [31:0] pc_q,    pc_d;
    logic [31:0] instr_q, instr_d;
    logic [5:0]  code_q,  code_d;
    logic [31:0] alu_q,   alu_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q,   err_d;

    assign op       = mem_op_t'(mem_op_in);
    assign is_load  = op_is_load(op);
    assign is_store = op_is_store(op);
    assign idx      = alu_result_in[AW+1:2];
    assign lane     = alu_result_in[1:0];
    assign rd_word  = mem_q[idx];

    always_comb begin
        misaligned = 1'b0;
        case (op)
            OP_LW, OP_SW:         misaligned = (lane != 2'b00);
            OP_LH, OP_LHU, OP_SH: misaligned = lane[0];
            default:              misaligned = 1'b0;
        endcase
        out_of_range = ({1'b0, alu_result_in} >= ADDR_LIMIT);
        err          = (is_load || is_store) && (misaligned || out_of_range);
    end

    load_ext u_load_ext (
        .word_i (rd_word),
        .lane_i (lane),
        .op_i   (op),
        .data_o (ext_data)
    );

    // Store data is replicated across lanes so the byte enables alone select the target bytes.
    always_comb begin
        be    = '0;
        wdata = '0;
        case (op)
            OP_SW: begin
                be    = 4'hF;
                wdata = store_data_in;
            end
            OP_SH: begin
                be    = lane[1] ? 4'b1100 : 4'b0011;
                wdata = {2{store_data_in[15:0]}};
            end
            OP_SB: begin
                be    = 4'b0001 << lane;
                wdata = {4{store_data_in[7:0]}};
            end
            default: begin
                be    = '0;
                wdata = '0;
            end
        endcase
        wr_en = is_store && !err && !stall_in;
    end

    always_comb begin
        pc_d    = pc_in;
        instr_d = instructure_in;
        code_d  = instr_code_in;
        alu_d   = alu_result_in;
        rdata_d = (is_load && !err) ? ext_data : '0;
        err_d   = err;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < DM_WORDS; i++) begin
                mem_q[i] <= '0;
            end
            pc_q    <= '0;
            instr_q <= '0;
            code_q  <= '0;
            alu_q   <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else if (!stall_in) begin
            pc_q    <= pc_d;
            instr_q <= instr_d;
            code_q  <= code_d;
            alu_q   <= alu_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            if (wr_en) begin
                for (int unsigned b = 0; b < 4; b++) begin
                    if (be[b]) begin
                        mem_q[idx][8*b +: 8] <= wdata[8*b +: 8];
                    end
                end
            end
        end
    end

    assign pc_out            = pc_q;
    assign instructure_out   = instr_q;
    assign instr_code_out    = code_q;
    assign alu_result_out    = alu_q;
    assign mem_read_data_out = rdata_q;
    assign addr_err_out      = err_q;

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: byte-array reference memory, expected MEM/WB contents queued per edge.
module tb_mem_stage;

    localparam int unsigned NBYTES = 4096;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] ins;
        logic [5:0]  code;
        logic [31:0] alu;
        logic [31:0] rd;
        logic        err;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall_in;
    logic [31:0] pc_in;
    logic [31:0] instructure_in;
    logic [5:0]  instr_code_in;
    logic [3:0]  mem_op_in;
    logic [31:0] alu_result_in;
    logic [31:0] store_data_in;
    logic [31:0] pc_out;
    logic [31:0] instructure_out;
    logic [5:0]  instr_code_out;
    logic [31:0] alu_result_out;
    logic [31:0] mem_read_data_out;
    logic        addr_err_out;

    int checks   = 0;
    int failures = 0;

    exp_t expq[$];
    exp_t last_e;
    logic [7:0] ref_mem [NBYTES];

    always #5 clk = ~clk;

    mem_stage #(.DM_WORDS(1024)) dut (
        .clk               (clk),
        .reset             (reset),
        .stall_in          (stall_in),
        .pc_in             (pc_in),
        .instructure_in    (instructure_in),
        .instr_code_in     (instr_code_in),
        .mem_op_in         (mem_op_in),
        .alu_result_in     (alu_result_in),
        .store_data_in     (store_data_in),
        .pc_out            (pc_out),
        .instructure_out   (instructure_out),
        .instr_code_out    (instr_code_out),
        .alu_result_out    (alu_result_out),
        .mem_read_data_out (mem_read_data_out),
        .addr_err_out      (addr_err_out)
    );

    function automatic exp_t zero_e();
        exp_t z;
        z.pc = '0; z.ins = '0; z.code = '0; z.alu = '0; z.rd = '0; z.err = 1'b0;
        return z;
    endfunction

    // Reference behaviour: little-endian byte memory, one call per clock edge.
    task automatic step(input logic rst, input logic stall, input int op,
                        input logic [31:0] addr, input logic [31:0] data);
        exp_t e;
        bit   is_ld, is_st, aligned, oor, err;
        logic [15:0] h;
        logic [7:0]  b;
        reset          = rst;
        stall_in       = stall;
        pc_in          = $urandom;
        instructure_in = $urandom;
        instr_code_in  = 6'($urandom);
        mem_op_in      = 4'(op);
        alu_result_in  = addr;
        store_data_in  = data;
        if (rst) begin
            e = zero_e();
            for (int i = 0; i < NBYTES; i++) ref_mem[i] = 8'h00;
            last_e = e;
        end else if (stall) begin
            e = last_e;
        end else begin
            is_ld   = (op >= 1 && op <= 5);
            is_st   = (op >= 6 && op <= 8);
            aligned = 1'b1;
            if (op == 1 || op == 6) aligned = (addr % 4 == 0);
            if (op == 2 || op == 3 || op == 7) aligned = (addr % 2 == 0);
            oor = (addr >= NBYTES);
            err = (is_ld || is_st) && (!aligned || oor);
            e.pc = pc_in; e.ins = instructure_in; e.code = instr_code_in;
            e.alu = addr; e.err = err; e.rd = '0;
            if (is_ld && !err) begin
                h = {ref_mem[addr + 1], ref_mem[addr]};
                b = ref_mem[addr];
                case (op)
                    1: e.rd = {ref_mem[addr + 3], ref_mem[addr + 2], ref_mem[addr + 1], ref_mem[addr]};
                    2: e.rd = {{16{h[15]}}, h};
                    3: e.rd = {16'h0, h};
                    4: e.rd = {{24{b[7]}}, b};
                    default: e.rd = {24'h0, b};
                endcase
            end
            if (is_st && !err) begin
                ref_mem[addr] = data[7:0];
                if (op == 6 || op == 7) ref_mem[addr + 1] = data[15:8];
                if (op == 6) begin
                    ref_mem[addr + 2] = data[23:16];
                    ref_mem[addr + 3] = data[31:24];
                end
            end
            last_e = e;
        end
        expq.push_back(e);
        @(posedge clk);
        #1;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (expq.size() > 0) begin
                e = expq.pop_front();
                checks++;
                if (pc_out !== e.pc || instructure_out !== e.ins || instr_code_out !== e.code ||
                    alu_result_out !== e.alu || mem_read_data_out !== e.rd || addr_err_out !== e.err) begin
                    failures++;
                    $display("FAIL out#%0d got pc=%h ins=%h code=%h alu=%h rd=%h err=%b want pc=%h ins=%h code=%h alu=%h rd=%h err=%b",
                             checks, pc_out, instructure_out, instr_code_out, alu_result_out,
                             mem_read_data_out, addr_err_out, e.pc, e.ins, e.code, e.alu, e.rd, e.err);
                end
            end
        end
    end

    initial begin : stim
        int op;
        logic [31:0] a;
        step(1, 0, 0, 32'h0, 32'h0);
        step(0, 0, 0, 32'h0, 32'h0);
        step(0, 0, 1, 32'h0, 32'h0);
        step(0, 0, 6, 32'h10, 32'h8badf00d);
        step(0, 0, 4, 32'h10, 32'h0);
        step(0, 0, 4, 32'h13, 32'h0);
        step(0, 0, 5, 32'h13, 32'h0);
        step(0, 0, 2, 32'h12, 32'h0);
        step(0, 0, 3, 32'h10, 32'h0);
        step(0, 0, 1, 32'h10, 32'h0);
        step(0, 0, 6, 32'h20, 32'h0);
        step(0, 0, 7, 32'h22, 32'h1234);
        step(0, 0, 8, 32'h21, 32'hab);
        step(0, 0, 1, 32'h20, 32'h0);
        step(0, 0, 6, 32'h16, 32'hffffffff);
        step(0, 0, 1, 32'h14, 32'h0);
        step(0, 0, 1, 32'h1000, 32'h0);
        step(0, 0, 1, 32'h30, 32'h0);
        for (int i = 0; i < 3; i++) step(0, 1, 6, 32'h30, 32'h55);
        step(0, 0, 6, 32'h30, 32'h55);
        step(0, 0, 1, 32'h30, 32'h0);
        step(0, 1, 6, 32'h34, 32'h77);
        step(1, 0, 6, 32'h34, 32'h99);
        step(0, 0, 1, 32'h34, 32'h0);
        for (int i = 0; i < 500; i++) begin
            op = int'($urandom_range(0, 15));
            case ($urandom_range(0, 9))
                0:       a = $urandom;
                1:       a = 32'($urandom_range(4088, 4100));
                default: a = 32'($urandom_range(0, 63));
            endcase
            step(($urandom_range(0, 99) == 0), ($urandom_range(0, 4) == 0), op, a, $urandom);
        end
        for (int i = 0; i < 10 && expq.size() > 0; i++) @(posedge clk);
        #1;
        if (expq.size() > 0) begin
            failures++;
            $display("FAIL drain got pending=%0d want pending=0", expq.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access stage of the five-stage MIPS pipeline, together with the MEM/WB pipeline register that feeds the write-back stage. Performs word, halfword and byte loads and stores against a private data memory, with alignment and range checking. Registers PC, instruction, instruction code, ALU result and load data for write-back.

## Interface
Parameters:
- DM_WORDS, 1024, data-memory depth in 32-bit words (4 KiB); power of two.

Ports:
- clk  in  1  rising-edge clock; the only clock.
- reset  in  1  synchronous, active-high reset.
- stall_in  in  1  holds the MEM/WB register and suppresses any store this cycle.
- pc_in  in  32  PC of the instruction in MEM.
- instructure_in  in  32  instruction word in MEM.
- instr_code_in  in  6  decoded instruction code in MEM.
- mem_op_in  in  4  memory operation (mem_op_t).
- alu_result_in  in  32  ALU result; the byte address for loads and stores.
- store_data_in  in  32  forwarded rt value, the store source.
- pc_out  out  32  registered to WB.
- instructure_out  out  32  registered to WB.
- instr_code_out  out  6  registered to WB.
- alu_result_out  out  32  registered to WB.
- mem_read_data_out  out  32  registered, extended load result.
- addr_err_out  out  1  registered; 1 when the access in the last MEM cycle was misaligned or out of range.

## Operation
- mem_op_t encodings: NONE=0, LW=1, LH=2, LHU=3, LB=4, LBU=5, SW=6, SH=7, SB=8. Codes 9–15 behave as NONE.
- Address: addr = alu_result_in. Word index = addr[log2(DM_WORDS)+1:2]. Byte lane = addr[1:0].
- Error: err = 1 if either condition holds:
  - misaligned: LW/SW with addr[1:0]≠0, or LH/LHU/SH with addr[0]≠0;
  - out of range: a load or store with addr ≥ 4·DM_WORDS.
  - err is always 0 for NONE.
- Stores: at the rising edge, when op is a store, err=0, stall_in=0 and reset=0:
  - SW writes the whole word.
  - SH writes bytes [2k+1:2k] with store_data_in[15:0], where k = addr[1].
  - SB writes byte addr[1:0] with store_data_in[7:0].
  - Other bytes are unchanged (byte-enable write).
  - Stores with err=1 are dropped.
- Loads: the array is read combinationally at the word index. Byte/half select:
  - LB sign-extends; LBU zero-extends.
  - LH sign-extends; LHU zero-extends.
  - LW returns the whole word.
- The load result is 0 when err=1 or for non-load ops.
- MEM/WB register, on each rising edge:
  - reset: all outputs clear to 0, and the whole memory clears to 0.
  - else stall_in=1: all outputs hold.
  - else: all outputs capture their next values.
- Priority: reset > stall_in > normal.

## Timing
- Reset values: pc_out, instructure_out, alu_result_out and mem_read_data_out = 32'h0; instr_code_out = 6'h0; addr_err_out = 0.
- Latency: an instruction present in MEM at edge N appears on the outputs after edge N. Its store commits at the same edge N.
- Store followed by load to the same word in the next cycle returns the new data; no bypass is needed.
- Under a store + stall, the memory write is suppressed every stalled cycle and commits once, on the first unstalled edge.
- Reset asserted mid-stream discards the in-flight instruction. The store at that edge is not performed.
- A held output under stall is bit-identical, including addr_err_out.

## Structure
- The shared package holds mem_op_t and its encodings, plus the DM_BYTES constant (4·DM_WORDS).
- Sub-module load_ext is combinational: inputs are the word, addr[1:0] and op; output is the 32-bit extended value.
- The storage array and byte-enable write logic live in mem_stage itself.

## Test plan
- Reset, then idle: all outputs 0. LW from 0x0 returns 0 (memory cleared).
- SW 0x8badf00d @0x10, then LB/LBU/LH/LHU/LW @0x10–0x13 on consecutive cycles:
  - LB @0x10 → 0x0000000d; LB @0x13 → 0xffffff8b; LBU @0x13 → 0x0000008b.
  - LH @0x12 → 0xffff8bad; LHU @0x10 → 0x0000f00d; LW @0x10 → 0x8badf00d.
- SW 0 @0x20, then SH 0x1234 @0x22, then SB 0xab @0x21 → LW @0x20 = 0x1234ab00.
- Misaligned SW @0x16 with 0xffffffff, then LW @0x14 → 0x00000000. addr_err_out=1 on the first result and 0 on the second.
- Out-of-range LW @0x1000 (DM_WORDS=1024) → mem_read_data_out=0, addr_err_out=1, alu_result_out=0x1000.
- SW 0x55 @0x30 held under stall_in=1 for 3 cycles: outputs frozen, memory unchanged. It commits on release; a following LW @0x30 → 0x00000055.
